// File: rtl/frame_serializer_pkg.sv
// Shared sample type and helpers for the frame serializer/deserializer pair.
// Both sides size their beat counter from beat_cnt_w() so N/2 indexing agrees.
package frame_serializer_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] r;
        logic signed [SAMPLE_W-1:0] i;
    } complex_product_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ACTIVE,
        S_ACTIVE_PEND
    } ser_state_e;

    // Beat counter width for an N-sample frame; never narrower than 1 bit (N = 2).
    function automatic int beat_cnt_w(input int n);
        return (n / 2 > 1) ? $clog2(n / 2) : 1;
    endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Frame-in / beat-out bundle. The serializer is the slave; the frame source
// and beat sink together form the master side.
interface frame_serializer_if
    import frame_serializer_pkg::*;
#(
    parameter int N = 8
);
    complex_product_t [N-1:0] x_parallel;
    logic                     in_valid;
    logic                     in_ready;
    complex_product_t         y_0;
    complex_product_t         y_1;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output x_parallel, in_valid, out_ready,
        input  in_ready, y_0, y_1, out_valid, out_last
    );

    modport slave (
        input  x_parallel, in_valid, out_ready,
        output in_ready, y_0, y_1, out_valid, out_last
    );
endinterface

// File: rtl/frame_serializer.sv
// Parallel-to-serial: one N-sample frame in, N/2 beats of two samples out,
// highest index first. Active + pending buffers give gapless back-to-back frames.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input logic               clk,
    input logic               reset,
    frame_serializer_if.slave bus
);
    localparam int BEATS = N / 2;
    localparam int CNT_W = beat_cnt_w(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef complex_product_t [N-1:0] frame_t;

    ser_state_e       state_q, state_d;
    frame_t           active_q, active_d;
    frame_t           pending_q, pending_d;
    frame_t           shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready_int, out_valid_int;
    logic accept, beat_done, last_beat;

    assign in_ready_int  = (state_q != S_ACTIVE_PEND);
    assign out_valid_int = (state_q != S_EMPTY);
    assign accept        = bus.in_valid & in_ready_int;
    assign beat_done     = out_valid_int & bus.out_ready;
    assign last_beat     = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY:       if (accept) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (beat_done && last_beat) state_d = accept ? S_ACTIVE : S_EMPTY;
                else if (accept)            state_d = S_ACTIVE_PEND;
            end
            S_ACTIVE_PEND: if (beat_done && last_beat) state_d = S_ACTIVE;
            default:       state_d = S_EMPTY;
        endcase
    end

    // The next beat always sits in the top two slots; consuming a beat shifts by two.
    always_comb begin
        shifted = '0;
        for (int i = 2; i < N; i++) shifted[i] = active_q[i-2];
    end

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (beat_done) begin
            if (last_beat) begin
                cnt_d = '0;
                if (state_q == S_ACTIVE_PEND) begin
                    active_d  = pending_q;
                    pending_d = '0;
                end else begin
                    active_d = accept ? bus.x_parallel : '0;
                end
            end else begin
                cnt_d    = cnt_q + 1'b1;
                active_d = shifted;
            end
        end
        if (accept && state_q == S_EMPTY) begin
            active_d = bus.x_parallel;
            cnt_d    = '0;
        end
        if (accept && state_q == S_ACTIVE && !(beat_done && last_beat))
            pending_d = bus.x_parallel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs depend on registered state only; reset forces in_ready low directly.
    always_comb begin
        bus.in_ready  = in_ready_int & ~reset;
        bus.out_valid = out_valid_int;
        bus.out_last  = out_valid_int & last_beat;
        bus.y_0       = out_valid_int ? active_q[N-1] : '0;
        bus.y_1       = out_valid_int ? active_q[N-2] : '0;
    end

endmodule
